// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory
// and writeback over a shared ALU and a unified memory port with ready.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            instrOpcode,
    input  logic [2:0]            instrFunct3,
    input  logic [6:0]            instrFunct7,
    input  logic                  aluZero,
    input  logic                  aluSign,
    input  logic                  aluCarry,
    input  logic                  aluOverflow,
    input  logic                  memReady,
    output logic                  memReq,
    output logic                  memWe,
    output logic                  iOrD,
    output logic                  irWrite,
    output logic                  pcWrite,
    output logic                  pcSrc,
    output logic [1:0]            aluSrcA,
    output logic [1:0]            aluSrcB,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  regWrite,
    output logic [1:0]            wdSrc,
    output logic                  illegal,
    output logic                  memFault,
    output logic [3:0]            state
);

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(9);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd15
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [7:0]              wait_cnt;
    logic                    wait_hit;
    logic                    timeout;
    logic                    illegal_q;
    logic                    fault_q;
    logic                    f7b5;
    logic                    is_r;
    logic [ALU_CTRL_W-1:0]   alu_fn;
    logic                    exec_bad;
    logic                    taken;
    logic                    br_bad;
    logic                    unused_bits;

    assign f7b5        = instrFunct7[5];
    assign is_r        = (state_q == EXEC_R);
    assign wait_hit    = !memReady && (wait_cnt == TO_LAST);
    assign unused_bits = ^{instrFunct7[6], instrFunct7[4:0]};

    assign state    = state_q;
    assign illegal  = illegal_q;
    assign memFault = fault_q;

    // ALU operation and legality from funct3/funct7[5]
    always_comb begin
        alu_fn = ALU_ADD;
        unique case (instrFunct3)
            3'b000: alu_fn = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_fn = ALU_SLL;
            3'b010: alu_fn = ALU_SLT;
            3'b011: alu_fn = ALU_SLTU;
            3'b100: alu_fn = ALU_XOR;
            3'b101: alu_fn = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_fn = ALU_OR;
            3'b111: alu_fn = ALU_AND;
        endcase
        if (is_r)
            exec_bad = f7b5 && (instrFunct3 != 3'b000)
                            && (instrFunct3 != 3'b101);
        else
            exec_bad = f7b5 && (instrFunct3 == 3'b001);
    end

    // Branch condition from the ALU flags of rs1 - rs2
    always_comb begin
        taken  = 1'b0;
        br_bad = 1'b0;
        case (instrFunct3)
            3'b000:  taken = aluZero;
            3'b001:  taken = !aluZero;
            3'b100:  taken = aluSign ^ aluOverflow;
            3'b101:  taken = !(aluSign ^ aluOverflow);
            3'b110:  taken = !aluCarry;
            3'b111:  taken = aluCarry;
            default: br_bad = 1'b1;
        endcase
    end

    // Next state and control outputs for the current state
    always_comb begin
        state_d    = state_q;
        timeout    = 1'b0;
        memReq     = 1'b0;
        memWe      = 1'b0;
        iOrD       = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = 1'b0;
        aluSrcA    = 2'd0;
        aluSrcB    = 2'd0;
        aluControl = ALU_ADD;
        regWrite   = 1'b0;
        wdSrc      = 2'd0;
        case (state_q)
            FETCH: begin
                memReq  = 1'b1;
                aluSrcB = 2'd2;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = DECODE;
                end else if (wait_hit) begin
                    timeout = 1'b1;
                    state_d = TRAP;
                end
            end
            DECODE: begin
                aluSrcA = 2'd2;
                aluSrcB = 2'd1;
                case (instrOpcode)
                    OPC_OP:     state_d = EXEC_R;
                    OPC_OP_IMM: state_d = EXEC_I;
                    OPC_LOAD:   state_d = MEM_ADDR;
                    OPC_STORE:  state_d = MEM_ADDR;
                    OPC_BRANCH: state_d = BRANCH;
                    OPC_JAL:    state_d = JAL;
                    OPC_LUI:    state_d = LUI;
                    default:    state_d = TRAP;
                endcase
            end
            EXEC_R, EXEC_I: begin
                aluSrcA    = 2'd1;
                aluSrcB    = is_r ? 2'd0 : 2'd1;
                aluControl = alu_fn;
                state_d    = exec_bad ? TRAP : ALU_WB;
            end
            ALU_WB: begin
                regWrite = 1'b1;
                state_d  = FETCH;
            end
            MEM_ADDR: begin
                aluSrcA = 2'd1;
                aluSrcB = 2'd1;
                if (instrFunct3 != 3'b010)
                    state_d = TRAP;
                else if (instrOpcode == OPC_STORE)
                    state_d = MEM_WR;
                else
                    state_d = MEM_RD;
            end
            MEM_RD: begin
                memReq = 1'b1;
                iOrD   = 1'b1;
                if (memReady) begin
                    state_d = MEM_WB;
                end else if (wait_hit) begin
                    timeout = 1'b1;
                    state_d = TRAP;
                end
            end
            MEM_WB: begin
                regWrite = 1'b1;
                wdSrc    = 2'd1;
                state_d  = FETCH;
            end
            MEM_WR: begin
                memReq = 1'b1;
                memWe  = 1'b1;
                iOrD   = 1'b1;
                if (memReady) begin
                    state_d = FETCH;
                end else if (wait_hit) begin
                    timeout = 1'b1;
                    state_d = TRAP;
                end
            end
            BRANCH: begin
                aluSrcA    = 2'd1;
                aluControl = ALU_SUB;
                if (br_bad) begin
                    state_d = TRAP;
                end else begin
                    pcWrite = taken;
                    pcSrc   = taken;
                    state_d = FETCH;
                end
            end
            JAL: begin
                regWrite = 1'b1;
                wdSrc    = 2'd2;
                pcWrite  = 1'b1;
                pcSrc    = 1'b1;
                state_d  = FETCH;
            end
            LUI: begin
                aluSrcA = 2'd3;
                aluSrcB = 2'd1;
                state_d = ALU_WB;
            end
            TRAP: state_d = TRAP_STICKY ? TRAP : FETCH;
            default: state_d = FETCH;
        endcase
        if (reset) begin
            state_d  = FETCH;
            timeout  = 1'b0;
            memReq   = 1'b0;
            memWe    = 1'b0;
            irWrite  = 1'b0;
            pcWrite  = 1'b0;
            regWrite = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // Memory wait counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (reset || state_d != state_q)
            wait_cnt <= 8'd0;
        else if (!memReady)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Sticky fault flags, classified on entry to TRAP
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else if (state_d == TRAP && state_q != TRAP) begin
            if (timeout)
                fault_q <= 1'b1;
            else
                illegal_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle stimulus and expected
// outputs are queued per scenario, then applied and compared cycle by cycle.
module tb_multicycle_control_unit;

    localparam logic [4:0] A_ADD  = 5'd0;
    localparam logic [4:0] A_SUB  = 5'd1;
    localparam logic [4:0] A_XOR  = 5'd2;
    localparam logic [4:0] A_SRA  = 5'd7;
    localparam logic [4:0] A_SLL  = 5'd5;
    localparam logic [4:0] A_SLTU = 5'd9;

    // {memReq, memWe, iOrD, irWrite, pcWrite, pcSrc, regWrite}
    localparam logic [6:0] NS = 7'b0000000;
    localparam logic [6:0] FR = 7'b1001100;
    localparam logic [6:0] FW = 7'b1000000;
    localparam logic [6:0] RD = 7'b1010000;
    localparam logic [6:0] WR = 7'b1110000;
    localparam logic [6:0] WB = 7'b0000001;
    localparam logic [6:0] PT = 7'b0000110;
    localparam logic [6:0] JL = 7'b0000111;
    localparam logic [6:0] AD = 7'b0010000;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic [3:0]  fl;
        logic [31:0] ins;
        logic [19:0] ev;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        aluZero, aluSign, aluCarry, aluOverflow;
    logic        memReady;
    logic        memReq, memWe, iOrD, irWrite, pcWrite, pcSrc;
    logic [1:0]  aluSrcA, aluSrcB, wdSrc;
    logic [4:0]  aluControl;
    logic        regWrite, illegal, memFault;
    logic [3:0]  state;
    logic [19:0] obs;

    item_t sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk),
        .reset(reset),
        .instrOpcode(instr[6:0]),
        .instrFunct3(instr[14:12]),
        .instrFunct7(instr[31:25]),
        .aluZero(aluZero),
        .aluSign(aluSign),
        .aluCarry(aluCarry),
        .aluOverflow(aluOverflow),
        .memReady(memReady),
        .memReq(memReq),
        .memWe(memWe),
        .iOrD(iOrD),
        .irWrite(irWrite),
        .pcWrite(pcWrite),
        .pcSrc(pcSrc),
        .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB),
        .aluControl(aluControl),
        .regWrite(regWrite),
        .wdSrc(wdSrc),
        .illegal(illegal),
        .memFault(memFault),
        .state(state)
    );

    assign obs = {state, aluControl, memReq, memWe, iOrD, irWrite,
                  pcWrite, pcSrc, regWrite, wdSrc, illegal, memFault};

    function automatic logic [31:0] mk(input logic [6:0] f7,
                                       input logic [2:0] f3,
                                       input logic [6:0] op);
        return {f7, 10'd0, f3, 5'd0, op};
    endfunction

    task automatic p(input logic r, input logic rdy,
                     input logic [3:0] fl, input logic [31:0] ins,
                     input logic [3:0] st, input logic [4:0] alu,
                     input logic [6:0] stb, input logic [1:0] wd,
                     input logic [1:0] fg);
        item_t e;
        e.rst = r;
        e.rdy = rdy;
        e.fl  = fl;
        e.ins = ins;
        e.ev  = {st, alu, stb, wd, fg};
        sb.push_back(e);
    endtask

    task automatic test_reset();
        item_t cur;
        int k = 0;
        p(1, 0, 0, 32'h0, 0, A_ADD, NS, 0, 0);
        p(1, 1, 0, 32'h0, 0, A_ADD, NS, 0, 0);
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            reset = cur.rst; memReady = cur.rdy; instr = cur.ins;
            {aluZero, aluSign, aluCarry, aluOverflow} = cur.fl;
            @(negedge clk);
            n_chk++;
            if (obs !== cur.ev)
                $display("FAIL reset step %0d: got %h want %h", k, obs, cur.ev);
            if (obs !== cur.ev) n_fail++;
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add();
        item_t cur;
        int k = 0;
        logic [31:0] i = 32'h002081B3;
        p(0, 1, 0, i, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, i, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, i, 2, A_ADD, NS, 0, 0);
        p(0, 1, 0, i, 4, A_ADD, WB, 0, 0);
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            reset = cur.rst; memReady = cur.rdy; instr = cur.ins;
            {aluZero, aluSign, aluCarry, aluOverflow} = cur.fl;
            @(negedge clk);
            n_chk++;
            if (obs !== cur.ev) begin
                n_fail++;
                $display("FAIL add step %0d: got %h want %h", k, obs, cur.ev);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        item_t cur;
        int k = 0;
        logic [31:0] sub   = mk(7'h20, 3'b000, 7'h33);
        logic [31:0] srai  = mk(7'h20, 3'b101, 7'h13);
        logic [31:0] addi  = mk(7'h20, 3'b000, 7'h13);
        logic [31:0] xr    = mk(7'h00, 3'b100, 7'h33);
        logic [31:0] sltiu = mk(7'h00, 3'b011, 7'h13);
        logic [31:0] lui   = mk(7'h55, 3'b101, 7'h37);
        logic [31:0] jal   = mk(7'h00, 3'b000, 7'h6F);
        p(0, 1, 0, sub, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, sub, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, sub, 2, A_SUB, NS, 0, 0);
        p(0, 1, 0, sub, 4, A_ADD, WB, 0, 0);
        p(0, 1, 0, srai, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, srai, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, srai, 3, A_SRA, NS, 0, 0);
        p(0, 1, 0, srai, 4, A_ADD, WB, 0, 0);
        p(0, 0, 0, addi, 0, A_ADD, FW, 0, 0);
        p(0, 0, 0, addi, 0, A_ADD, FW, 0, 0);
        p(0, 1, 0, addi, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, addi, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, addi, 3, A_ADD, NS, 0, 0);
        p(0, 1, 0, addi, 4, A_ADD, WB, 0, 0);
        p(0, 1, 0, xr, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, xr, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, xr, 2, A_XOR, NS, 0, 0);
        p(0, 1, 0, xr, 4, A_ADD, WB, 0, 0);
        p(0, 1, 0, sltiu, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, sltiu, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, sltiu, 3, A_SLTU, NS, 0, 0);
        p(0, 1, 0, sltiu, 4, A_ADD, WB, 0, 0);
        p(0, 1, 0, lui, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, lui, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, lui, 11, A_ADD, NS, 0, 0);
        p(0, 1, 0, lui, 4, A_ADD, WB, 0, 0);
        p(0, 1, 0, jal, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, jal, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, jal, 10, A_ADD, JL, 2, 0);
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            reset = cur.rst; memReady = cur.rdy; instr = cur.ins;
            {aluZero, aluSign, aluCarry, aluOverflow} = cur.fl;
            @(negedge clk);
            n_chk++;
            if (obs !== cur.ev) begin
                n_fail++;
                $display("FAIL b2b step %0d: got %h want %h", k, obs, cur.ev);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        item_t cur;
        int k = 0;
        logic [31:0] blt  = mk(7'h00, 3'b100, 7'h63);
        logic [31:0] bgeu = mk(7'h00, 3'b111, 7'h63);
        logic [31:0] beq  = mk(7'h00, 3'b000, 7'h63);
        logic [31:0] bne  = mk(7'h00, 3'b001, 7'h63);
        // fl = {zero, sign, carry, overflow}
        p(0, 1, 4'b0100, blt, 0, A_ADD, FR, 0, 0);
        p(0, 1, 4'b0100, blt, 1, A_ADD, NS, 0, 0);
        p(0, 1, 4'b0100, blt, 9, A_SUB, PT, 0, 0);
        p(0, 1, 4'b0000, bgeu, 0, A_ADD, FR, 0, 0);
        p(0, 1, 4'b0000, bgeu, 1, A_ADD, NS, 0, 0);
        p(0, 1, 4'b0000, bgeu, 9, A_SUB, NS, 0, 0);
        p(0, 1, 4'b1000, beq, 0, A_ADD, FR, 0, 0);
        p(0, 1, 4'b1000, beq, 1, A_ADD, NS, 0, 0);
        p(0, 1, 4'b1000, beq, 9, A_SUB, PT, 0, 0);
        p(0, 1, 4'b1000, bne, 0, A_ADD, FR, 0, 0);
        p(0, 1, 4'b1000, bne, 1, A_ADD, NS, 0, 0);
        p(0, 1, 4'b1000, bne, 9, A_SUB, NS, 0, 0);
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            reset = cur.rst; memReady = cur.rdy; instr = cur.ins;
            {aluZero, aluSign, aluCarry, aluOverflow} = cur.fl;
            @(negedge clk);
            n_chk++;
            if (obs !== cur.ev) begin
                n_fail++;
                $display("FAIL branch step %0d: got %h want %h", k, obs, cur.ev);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_store();
        item_t cur;
        int k = 0;
        logic [31:0] lw = mk(7'h00, 3'b010, 7'h03);
        logic [31:0] sw = mk(7'h00, 3'b010, 7'h23);
        p(0, 1, 0, lw, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, lw, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, lw, 5, A_ADD, NS, 0, 0);
        for (int n = 0; n < 3; n++)
            p(0, 0, 0, lw, 6, A_ADD, RD, 0, 0);
        p(0, 1, 0, lw, 6, A_ADD, RD, 0, 0);
        p(0, 1, 0, lw, 7, A_ADD, WB, 1, 0);
        p(0, 1, 0, sw, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, sw, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, sw, 5, A_ADD, NS, 0, 0);
        p(0, 1, 0, sw, 8, A_ADD, WR, 0, 0);
        p(0, 1, 0, lw, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, lw, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, lw, 5, A_ADD, NS, 0, 0);
        for (int n = 0; n < 14; n++)
            p(0, 0, 0, lw, 6, A_ADD, RD, 0, 0);
        p(0, 1, 0, lw, 6, A_ADD, RD, 0, 0);
        p(0, 1, 0, lw, 7, A_ADD, WB, 1, 0);
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            reset = cur.rst; memReady = cur.rdy; instr = cur.ins;
            {aluZero, aluSign, aluCarry, aluOverflow} = cur.fl;
            @(negedge clk);
            n_chk++;
            if (obs !== cur.ev) begin
                n_fail++;
                $display("FAIL ldst step %0d: got %h want %h", k, obs, cur.ev);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_traps();
        item_t cur;
        int k = 0;
        logic [31:0] bad  = mk(7'h00, 3'b010, 7'h63);
        logic [31:0] slli = mk(7'h20, 3'b001, 7'h13);
        logic [31:0] fnc  = mk(7'h00, 3'b000, 7'h0F);
        logic [31:0] sw   = mk(7'h00, 3'b010, 7'h23);
        logic [31:0] lw   = mk(7'h00, 3'b010, 7'h03);
        p(0, 1, 0, bad, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, bad, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, bad, 9, A_SUB, NS, 0, 0);
        p(0, 1, 0, bad, 15, A_ADD, NS, 0, 2'b10);
        p(1, 1, 0, bad, 15, A_ADD, NS, 0, 2'b10);
        p(0, 0, 0, bad, 0, A_ADD, FW, 0, 0);
        p(0, 1, 0, slli, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, slli, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, slli, 3, A_SLL, NS, 0, 0);
        p(0, 1, 0, slli, 15, A_ADD, NS, 0, 2'b10);
        p(1, 1, 0, slli, 15, A_ADD, NS, 0, 2'b10);
        p(0, 0, 0, slli, 0, A_ADD, FW, 0, 0);
        p(0, 1, 0, sw, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, sw, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, sw, 5, A_ADD, NS, 0, 0);
        for (int n = 0; n < 15; n++)
            p(0, 0, 0, sw, 8, A_ADD, WR, 0, 0);
        p(0, 0, 0, sw, 15, A_ADD, NS, 0, 2'b01);
        p(1, 0, 0, sw, 15, A_ADD, NS, 0, 2'b01);
        p(0, 0, 0, fnc, 0, A_ADD, FW, 0, 0);
        p(0, 1, 0, fnc, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, fnc, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, fnc, 15, A_ADD, NS, 0, 2'b10);
        p(0, 1, 0, fnc, 15, A_ADD, NS, 0, 2'b10);
        p(1, 1, 0, fnc, 15, A_ADD, NS, 0, 2'b10);
        p(0, 0, 0, lw, 0, A_ADD, FW, 0, 0);
        p(0, 1, 0, lw, 0, A_ADD, FR, 0, 0);
        p(0, 1, 0, lw, 1, A_ADD, NS, 0, 0);
        p(0, 1, 0, lw, 5, A_ADD, NS, 0, 0);
        p(0, 0, 0, lw, 6, A_ADD, RD, 0, 0);
        p(1, 1, 0, lw, 6, A_ADD, AD, 0, 0);
        for (int n = 0; n < 15; n++)
            p(0, 0, 0, lw, 0, A_ADD, FW, 0, 0);
        p(0, 0, 0, lw, 15, A_ADD, NS, 0, 2'b01);
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            reset = cur.rst; memReady = cur.rdy; instr = cur.ins;
            {aluZero, aluSign, aluCarry, aluOverflow} = cur.fl;
            @(negedge clk);
            n_chk++;
            if (obs !== cur.ev) begin
                n_fail++;
                $display("FAIL trap step %0d: got %h want %h", k, obs, cur.ev);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        memReady = 1'b0;
        instr = 32'h0;
        {aluZero, aluSign, aluCarry, aluOverflow} = 4'b0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_branch();
        test_load_store();
        test_traps();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
